mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit operands and 64-bit HI:LO result.
REQ-002 mdu_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 mdu_rst  input  1  reset, asynchronous and active-high.
REQ-004 mdu_start  input  1  request to begin an operation; sampled on rising mdu_clk.
REQ-005 mdu_op  input  2  operation code: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 mdu_a  input  32  first operand (multiplicand or dividend), driven from the register file first read port.
REQ-007 mdu_b  input  32  second operand (multiplier or divisor), driven from the register file second read port.
REQ-008 mdu_hi_we, mdu_lo_we  input  1 each  MTHI/MTLO write enables.
REQ-009 mdu_wdata  input  32  MTHI/MTLO write data.
REQ-010 mdu_busy  output  1  high while an operation is in progress.
REQ-011 mdu_done  output  1  one-cycle pulse when a result has been committed to HI/LO.
REQ-012 mdu_hi, mdu_lo  output  32 each  architectural HI and LO registers, driven directly from flops.

Function
REQ-013 The FSM SHALL have exactly three states:
- IDLE
- RUN, with a 5-bit iteration counter
- FIN
REQ-014 In IDLE, mdu_start=1 at edge E0 SHALL latch mdu_op, mdu_a and mdu_b, clear the counter, and enter RUN.
- mdu_busy SHALL be 1 from E0 onward.
REQ-015 RUN SHALL perform one radix-2 iteration per edge, E1..E32, on operand magnitudes.
- Multiply: shift-add.
- Divide: restoring shift-subtract.
- RUN SHALL go to FIN at E32, when counter=31.
REQ-016 FIN SHALL apply sign correction, and edge E33 SHALL do all of the following together:
- write HI/LO
- return to IDLE
- drive mdu_busy=0 and mdu_done=1
REQ-017 mdu_done SHALL fall at E34 unless a new result completes at that edge; total latency from start to done is 33 edges, independent of operand values.
REQ-018 mdu_start while not in IDLE SHALL be ignored, with no queuing; a start SHALL be accepted at the earliest at the edge after mdu_busy falls.
REQ-019 MULT and MULTU SHALL produce the full 64-bit product, with HI=product[63:32] and LO=product[31:0].
- MULTU treats operands as unsigned.
- MULT treats operands as two's complement.
REQ-020 DIV and DIVU SHALL produce LO=quotient and HI=remainder.
- DIV quotient truncates toward zero.
- DIV remainder takes the sign of the dividend.
REQ-021 Divide by zero SHALL still take 33 edges and produce LO=32'hFFFFFFFF and HI=dividend, for both DIV and DIVU.
REQ-022 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL produce LO=32'h80000000 and HI=0.
REQ-023 mdu_hi_we=1 in IDLE SHALL load HI from mdu_wdata at that edge; mdu_lo_we behaves the same for LO; both may be set in the same cycle.
REQ-024 mdu_hi_we and mdu_lo_we SHALL be ignored in RUN and FIN.
REQ-025 mdu_start together with mdu_hi_we or mdu_lo_we in IDLE SHALL accept both.
- The MTHI/MTLO write takes effect at E0.
- The operation result overwrites HI/LO at E33.
REQ-026 HI/LO SHALL hold their prior values throughout RUN and FIN; no partial results are visible.

Reset
REQ-027 mdu_rst=1 SHALL immediately, without waiting for a clock edge, force all of the following:
- state=IDLE
- mdu_busy=0, mdu_done=0
- mdu_hi=0, mdu_lo=0
- counter and all internal accumulators to 0
REQ-028 Reset during RUN or FIN SHALL discard the operation, with no mdu_done pulse afterwards.
REQ-029 The first start SHALL be accepted at the first rising edge at which mdu_rst is low.

Verification
REQ-030 MULTU a=32'hFFFFFFFF b=32'hFFFFFFFF -> 33 edges later mdu_done=1, HI=32'hFFFFFFFE, LO=32'h00000001.
REQ-031 MULT a=32'hFFFFFFFD (-3) b=7 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFEB (-21).
REQ-032 Divide cases:
- DIV a=-7 b=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- DIVU a=7 b=0 -> LO=32'hFFFFFFFF, HI=7, after 33 edges.
- DIV a=32'h80000000 b=32'hFFFFFFFF -> LO=32'h80000000, HI=0.
REQ-033 Start MULTU 3x5, then pulse mdu_start with DIVU and mdu_lo_we=1 (wdata=9) at edge 5 -> both ignored; done at E33 with HI=0, LO=15.
REQ-034 Start DIVU 100/7, assert mdu_rst mid-cycle between edges 10 and 11 -> busy=0 and HI=LO=0 before the next edge; no done pulse; then a new MULTU 2x2 gives LO=4.
REQ-035 In IDLE, mdu_lo_we=1 with wdata=32'h1234 and mdu_hi_we=1 in the same cycle -> after the edge, LO=32'h1234 and HI=32'h1234; mdu_busy stays 0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit: 33 edges from start to committed HI/LO.
// Multiply is shift-add and divide is restoring; both work on magnitudes, with sign fix-up in FIN.
module mult_div_unit (
    input  logic        mdu_clk,
    input  logic        mdu_rst,
    input  logic        mdu_start,
    input  logic [1:0]  mdu_op,
    input  logic [31:0] mdu_a,
    input  logic [31:0] mdu_b,
    input  logic        mdu_hi_we,
    input  logic        mdu_lo_we,
    input  logic [31:0] mdu_wdata,
    output logic        mdu_busy,
    output logic        mdu_done,
    output logic [31:0] mdu_hi,
    output logic [31:0] mdu_lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        div_q, div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] b_mag_q, b_mag_d;
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [31:0] acc_lo_q, acc_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        sign_a, sign_b;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_fits;
    logic [63:0] product;
    logic [31:0] quo_fix, rem_fix;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        b_mag_d   = b_mag_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        sign_a    = mdu_op[0] & mdu_a[31];
        sign_b    = mdu_op[0] & mdu_b[31];
        a_mag     = sign_a ? (32'd0 - mdu_a) : mdu_a;
        b_mag     = sign_b ? (32'd0 - mdu_b) : mdu_b;

        // Multiply: acc_hi:acc_lo shifts right, acc_lo starts as the multiplier.
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_mag_q} : 33'd0);
        // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
        div_shift = {acc_hi_q, acc_lo_q[31]};
        div_fits  = (div_shift >= {1'b0, b_mag_q});

        product   = {acc_hi_q, acc_lo_q};
        if (neg_res_q) begin
            product = 64'd0 - product;
        end
        quo_fix   = neg_res_q ? (32'd0 - acc_lo_q) : acc_lo_q;
        rem_fix   = neg_rem_q ? (32'd0 - acc_hi_q) : acc_hi_q;

        unique case (state_q)
            IDLE: begin
                if (mdu_hi_we) begin
                    hi_d = mdu_wdata;
                end
                if (mdu_lo_we) begin
                    lo_d = mdu_wdata;
                end
                if (mdu_start) begin
                    state_d   = RUN;
                    cnt_d     = 5'd0;
                    div_d     = mdu_op[1];
                    neg_res_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    b_mag_d   = b_mag;
                    acc_hi_d  = 32'd0;
                    acc_lo_d  = a_mag;
                end
            end
            RUN: begin
                if (div_q) begin
                    // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
                    acc_hi_d = div_fits ? (div_shift[31:0] - b_mag_q) : div_shift[31:0];
                    acc_lo_d = {acc_lo_q[30:0], div_fits};
                end else begin
                    acc_hi_d = mul_sum[32:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                if (div_q) begin
                    hi_d = rem_fix;
                    lo_d = (b_mag_q == 32'd0) ? 32'hFFFF_FFFF : quo_fix;
                end else begin
                    hi_d = product[63:32];
                    lo_d = product[31:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge mdu_clk or posedge mdu_rst) begin
        if (mdu_rst) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_mag_q   <= 32'd0;
            acc_hi_q  <= 32'd0;
            acc_lo_q  <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            b_mag_q   <= b_mag_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign mdu_busy = (state_q != IDLE);
    assign mdu_done = done_q;
    assign mdu_hi   = hi_q;
    assign mdu_lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus randomized checks of mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

    logic        mdu_clk = 1'b0;
    logic        mdu_rst = 1'b1;
    logic        mdu_start = 1'b0;
    logic [1:0]  mdu_op = 2'd0;
    logic [31:0] mdu_a = 32'd0;
    logic [31:0] mdu_b = 32'd0;
    logic        mdu_hi_we = 1'b0;
    logic        mdu_lo_we = 1'b0;
    logic [31:0] mdu_wdata = 32'd0;
    logic        mdu_busy;
    logic        mdu_done;
    logic [31:0] mdu_hi;
    logic [31:0] mdu_lo;

    int          vec_cnt = 0;
    int          miss_cnt = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mult_div_unit dut (
        .mdu_clk   (mdu_clk),
        .mdu_rst   (mdu_rst),
        .mdu_start (mdu_start),
        .mdu_op    (mdu_op),
        .mdu_a     (mdu_a),
        .mdu_b     (mdu_b),
        .mdu_hi_we (mdu_hi_we),
        .mdu_lo_we (mdu_lo_we),
        .mdu_wdata (mdu_wdata),
        .mdu_busy  (mdu_busy),
        .mdu_done  (mdu_done),
        .mdu_hi    (mdu_hi),
        .mdu_lo    (mdu_lo)
    );

    always #5 mdu_clk = ~mdu_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: MIPS HI/LO semantics from plain arithmetic.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rh, output logic [31:0] rl);
        logic [63:0] p;
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            2'b00: p = {32'd0, a} * {32'd0, b};
            2'b01: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            2'b10: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else        p = {a % b, a / b};
            end
            default: begin
                if (b == 0)                                   p = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == '1)       p = {32'd0, 32'h8000_0000};
                else                                          p = {32'(sa % sb), 32'(sa / sb)};
            end
        endcase
        rh = p[63:32];
        rl = p[31:0];
    endtask

    // Issues a start at the next edge (E0) and checks through E33.
    // mode 1 injects an ignored start + MTLO before E5; mt_hi pairs an MTHI with the start.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int mode, input logic mt_hi);
        logic [31:0] rh, rl;
        model(op, a, b, rh, rl);
        mdu_start = 1'b1;
        mdu_op    = op;
        mdu_a     = a;
        mdu_b     = b;
        mdu_hi_we = mt_hi;
        mdu_wdata = $urandom;
        @(posedge mdu_clk); #1;
        if (mt_hi) exp_hi = mdu_wdata;
        mdu_start = 1'b0;
        mdu_hi_we = 1'b0;
        mdu_a     = $urandom;
        mdu_b     = $urandom;
        check("busy_e0", {63'd0, mdu_busy}, 64'd1);
        check("done_e0", {63'd0, mdu_done}, 64'd0);
        check("hi_e0", {32'd0, mdu_hi}, {32'd0, exp_hi});
        for (int e = 1; e <= 32; e++) begin
            if (mode == 1 && e == 5) begin
                mdu_start = 1'b1;
                mdu_op    = 2'b10;
                mdu_lo_we = 1'b1;
                mdu_wdata = 32'd9;
            end
            @(posedge mdu_clk); #1;
            mdu_start = 1'b0;
            mdu_lo_we = 1'b0;
            if (e == 16) begin
                check("hold_hilo", {mdu_hi, mdu_lo}, {exp_hi, exp_lo});
            end
        end
        check("busy_e32", {62'd0, mdu_busy, mdu_done}, 64'd2);
        @(posedge mdu_clk); #1;
        exp_hi = rh;
        exp_lo = rl;
        check("done_e33", {62'd0, mdu_busy, mdu_done}, 64'd1);
        check($sformatf("result op%0d %h,%h", op, a, b), {mdu_hi, mdu_lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        int dones;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        #1;
        check("rst_outputs", {mdu_busy, mdu_done, mdu_hi, mdu_lo}, 66'd0);
        repeat (2) @(posedge mdu_clk);
        #1 mdu_rst = 1'b0;

        // MTHI and MTLO together at the first edge after reset
        mdu_hi_we = 1'b1;
        mdu_lo_we = 1'b1;
        mdu_wdata = 32'h1234;
        @(posedge mdu_clk); #1;
        mdu_hi_we = 1'b0;
        mdu_lo_we = 1'b0;
        exp_hi = 32'h1234;
        exp_lo = 32'h1234;
        check("mt_both", {mdu_hi, mdu_lo}, {exp_hi, exp_lo});
        check("mt_busy", {63'd0, mdu_busy}, 64'd0);

        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        check("multu_max", {mdu_hi, mdu_lo}, 64'hFFFF_FFFE_0000_0001);
        do_op(2'b01, 32'hFFFF_FFFD, 32'd7, 0, 1'b0);
        check("mult_neg", {mdu_hi, mdu_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        check("div_neg", {mdu_hi, mdu_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(2'b10, 32'd7, 32'd0, 0, 1'b0);
        check("divu_zero", {mdu_hi, mdu_lo}, 64'h0000_0007_FFFF_FFFF);
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        check("div_ovf", {mdu_hi, mdu_lo}, 64'h0000_0000_8000_0000);
        do_op(2'b11, 32'hFFFF_FFF0, 32'd0, 0, 1'b0);
        check("div_zero_neg", {mdu_hi, mdu_lo}, 64'hFFFF_FFF0_FFFF_FFFF);

        // Start/MTLO during RUN ignored; no queued op afterwards
        do_op(2'b00, 32'd3, 32'd5, 1, 1'b0);
        check("ignored_start", {mdu_hi, mdu_lo}, 64'd15);
        @(posedge mdu_clk); #1;
        check("no_queue", {62'd0, mdu_busy, mdu_done}, 64'd0);

        // Start together with MTHI
        do_op(2'b10, 32'd100, 32'd7, 0, 1'b1);

        // Reset between edges 10 and 11 discards the operation
        mdu_start = 1'b1;
        mdu_op    = 2'b10;
        mdu_a     = 32'd100;
        mdu_b     = 32'd7;
        @(posedge mdu_clk); #1;
        mdu_start = 1'b0;
        repeat (10) @(posedge mdu_clk);
        #5 mdu_rst = 1'b1;
        #1;
        check("async_rst", {mdu_busy, mdu_done, mdu_hi, mdu_lo}, 66'd0);
        #1 mdu_rst = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        dones = 0;
        repeat (40) begin
            @(posedge mdu_clk); #1;
            if (mdu_done) dones++;
        end
        check("no_done_after_rst", 64'(dones), 64'd0);
        do_op(2'b00, 32'd2, 32'd2, 0, 1'b0);
        check("mult_after_rst", {32'd0, mdu_lo}, 64'd4);

        // Randomized back-to-back operations with occasional corner operands
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 9));
                3: ra = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
                default: ;
            endcase
            do_op(rop, ra, rb, 0, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
